pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined LEGv8 core. Fetch stage reads its PC.
- Adds to the basic counter/jump behaviour:
  - configurable width, step and reset vector
  - stall hold and priority-ordered redirect
  - halt/resume state machine
  - small return-address stack (RAS) for BL/RET prediction
- All state updates on the rising clock edge only.

Parameters:
WIDTH, 64, PC width in bits
STEP, 4, sequential increment in bytes (power of two, >=1)
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold sequential increment
redirect_en  in  1  taken branch/jump; load redirect_target
redirect_target  in  WIDTH  branch/jump destination
call_en  in  1  BL: push return address (qualified by redirect_en)
ret_en  in  1  RET: pop RAS top into PC
halt  in  1  enter HALT
resume  in  1  leave HALT
pc  out  WIDTH  current fetch address
pc_valid  out  1  pc is a real fetch address
ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_overflow  out  1  sticky: push when full
ras_underflow  out  1  sticky: pop when empty
misalign_fault  out  1  one-cycle pulse, see Optional Feature

Behaviour:
- Clock and reset: one clock; reset_n is asynchronous and active-low.
- Reset values (asserted immediately, asynchronously):
  - pc = RESET_VECTOR
  - pc_valid = 0
  - ras_count = 0
  - ras_overflow = 0, ras_underflow = 0, misalign_fault = 0
  - state = BOOT
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle after reset release. pc holds RESET_VECTOR, pc_valid = 0, all inputs ignored. Next state RUN.
  - RUN: pc_valid = 1. If halt = 1, next state is HALT; pc and RAS are still updated that cycle by the rules below.
  - HALT: pc_valid = 0. pc and RAS hold; redirect/call/ret/stall are ignored. resume = 1 returns to RUN next cycle. halt and resume both 1 in HALT: stay in HALT.
- Next-pc priority in RUN (first match wins):
  1. redirect_en = 1: pc <= redirect_target. If call_en = 1, also push pc+STEP.
  2. ret_en = 1 and ras_count > 0: pc <= top entry; pop.
  3. ret_en = 1 and ras_count = 0: ras_underflow <= 1; then fall through to rule 4/5.
  4. stall = 1: pc holds.
  5. Otherwise: pc <= pc + STEP.
- Interaction rules:
  - call_en without redirect_en is ignored.
  - ret_en together with redirect_en: redirect wins, no pop.
  - stall does not block rules 1 or 2.
- Arithmetic: pc + STEP is modulo 2^WIDTH, so all-ones minus STEP-1 wraps to 0. Pushed return addresses wrap the same way.
- RAS:
  - Circular buffer: top pointer plus count.
  - Push when count = RAS_DEPTH: the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow <= 1.
  - Pop returns the most recent push (LIFO).
  - Sticky flags clear only on reset.
- Latency: every update is visible on pc one cycle after the inputs are sampled.
- Reset mid-operation: all state returns to reset values immediately; the RAS contents are discarded via count = 0.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: on rule 1, if the low log2(STEP) bits of redirect_target are nonzero:
  - pc loads the target with those bits cleared
  - misalign_fault pulses high for one cycle
  The check applies to redirect only, not to RAS pops.
- Undefined: redirect_target is loaded unmodified; misalign_fault is tied to 0.
- With STEP = 1 the feature has no effect.

Test Plan:
- Reset release, no other stimulus, defaults (WIDTH=64, STEP=4) -> cycle 0 after release: pc=0, pc_valid=0; then pc=0, 4, 8, 12 with pc_valid=1.
- At pc=8: stall=1 for 3 cycles -> pc stays 8; release -> 12. At pc=12: stall=1 with redirect_en=1, target=0x100 -> pc=0x100 next cycle.
- At pc=0x100: redirect_en=1, call_en=1, target=0x400 -> pc=0x400, ras_count=1. Run 2 cycles (pc=0x408), then ret_en=1 -> pc=0x104, ras_count=0.
- 5 calls with RAS_DEPTH=4 -> ras_overflow=1, ras_count=4. 4 rets return the last 4 return addresses in reverse order. A 5th ret -> ras_underflow=1 and pc advances by 4.
- WIDTH=8, STEP=4, pc=0xFC, no stall -> pc=0x00. Then halt=1 -> pc=0x04 and state HALT next cycle, pc_valid=0; pc holds through redirect attempts. resume=1 -> RUN, pc=0x04, then 0x08.
- PC_ALIGN_CHECK_EN defined: redirect target=0x203 -> pc=0x200, misalign_fault high for exactly 1 cycle. Same stimulus with the macro undefined -> pc=0x203, fault stays 0.

Source files
------------

// File: rtl/pc_unit_if.sv
// Request/status bundle between the fetch stage and the program-counter unit.
interface pc_unit_if #(
    parameter int WIDTH     = 64,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             stall;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_target;
    logic             call_en;
    logic             ret_en;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic [CNT_W-1:0] ras_count;
    logic             ras_overflow;
    logic             ras_underflow;
    logic             misalign_fault;

    modport master (
        output stall, redirect_en, redirect_target, call_en, ret_en, halt, resume,
        input  pc, pc_valid, ras_count, ras_overflow, ras_underflow, misalign_fault
    );

    modport slave (
        input  stall, redirect_en, redirect_target, call_en, ret_en, halt, resume,
        output pc, pc_valid, ras_count, ras_overflow, ras_underflow, misalign_fault
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with stall, prioritised redirect, halt/resume FSM and a return-address stack.
// Optional build macro PC_ALIGN_CHECK_EN: force redirect targets onto a STEP boundary and flag it.
module pc_unit #(
    parameter int               WIDTH        = 64,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input logic        clock,
    input logic        reset_n,
    pc_unit_if.slave   bus
);
    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam int               CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [PTR_W-1:0] top_reg, top_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             fault_reg, fault_next;
    logic             push, pop;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] target_eff;
    logic             target_misaligned;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    assign pc_seq = pc_reg + STEP_W;

`ifdef PC_ALIGN_CHECK_EN
    assign target_misaligned = |(bus.redirect_target & ALIGN_MASK);
    assign target_eff        = bus.redirect_target & ~ALIGN_MASK;
`else
    assign target_misaligned = 1'b0;
    assign target_eff        = bus.redirect_target;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        pop        = 1'b0;
        unf_next   = unf_reg;
        fault_next = 1'b0;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                if (bus.halt) state_next = HALT;
                if (bus.redirect_en) begin
                    pc_next    = target_eff;
                    fault_next = target_misaligned;
                    push       = bus.call_en;
                end else if (bus.ret_en && count_reg != '0) begin
                    pc_next = ras_mem[top_reg];
                    pop     = 1'b1;
                end else begin
                    // An empty-stack return is flagged, then behaves like a plain cycle.
                    if (bus.ret_en) unf_next = 1'b1;
                    if (!bus.stall) pc_next = pc_seq;
                end
            end
            HALT: begin
                if (bus.resume && !bus.halt) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (push) begin
            // Full stack: the new entry lands on the oldest slot of the ring.
            top_next = top_reg + PTR_W'(1);
            if (count_reg == CNT_W'(RAS_DEPTH)) ovf_next = 1'b1;
            else                                count_next = count_reg + CNT_W'(1);
        end else if (pop) begin
            top_next   = top_reg - PTR_W'(1);
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_VECTOR;
            top_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            top_reg   <= top_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            fault_reg <= fault_next;
        end
    end

    // Entries carry no reset; count alone decides which ones are live.
    always_ff @(posedge clock) begin
        if (push) ras_mem[top_next] <= pc_seq;
    end

    assign bus.pc             = pc_reg;
    assign bus.pc_valid       = (state_reg == RUN);
    assign bus.ras_count      = count_reg;
    assign bus.ras_overflow   = ovf_reg;
    assign bus.ras_underflow  = unf_reg;
    assign bus.misalign_fault = fault_reg;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 64-bit instance for flow/RAS checks and an 8-bit one for wrap and halt.
module tb_pc_unit;
    logic clock = 1'b0;
    logic reset_n64, reset_n8;
    always #5 clock = ~clock;

    pc_unit_if #(.WIDTH(64), .RAS_DEPTH(4)) b64 ();
    pc_unit_if #(.WIDTH(8),  .RAS_DEPTH(4)) b8 ();

    pc_unit #(.WIDTH(64), .STEP(4), .RESET_VECTOR(64'h0), .RAS_DEPTH(4)) dut64 (
        .clock(clock), .reset_n(reset_n64), .bus(b64.slave));
    pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hF4), .RAS_DEPTH(4)) dut8 (
        .clock(clock), .reset_n(reset_n8), .bus(b8.slave));

    typedef struct {
        int          sel;
        string       tag;
        logic [63:0] pc;
        logic        valid;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input string field, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic compare(input exp_t e);
        logic [63:0] opc;
        logic ov, oo, ou, of;
        logic [2:0] oc;
        if (e.sel == 0) begin
            opc = b64.pc; ov = b64.pc_valid; oc = b64.ras_count;
            oo = b64.ras_overflow; ou = b64.ras_underflow; of = b64.misalign_fault;
        end else begin
            opc = {56'h0, b8.pc}; ov = b8.pc_valid; oc = b8.ras_count;
            oo = b8.ras_overflow; ou = b8.ras_underflow; of = b8.misalign_fault;
        end
        $display("txn %-14s pc=%h valid=%b cnt=%0d ovf=%b unf=%b fault=%b", e.tag, opc, ov, oc, oo, ou, of);
        check(e.tag, "pc", opc, e.pc);
        check(e.tag, "pc_valid", {63'h0, ov}, {63'h0, e.valid});
        check(e.tag, "ras_count", {61'h0, oc}, {61'h0, e.cnt});
        check(e.tag, "ras_overflow", {63'h0, oo}, {63'h0, e.ovf});
        check(e.tag, "ras_underflow", {63'h0, ou}, {63'h0, e.unf});
        check(e.tag, "misalign_fault", {63'h0, of}, {63'h0, e.fault});
    endtask

    // Expectation is queued when the stimulus is applied, then retired one edge later.
    task automatic step(input int sel, input string tag, input logic [63:0] epc, input logic ev,
                        input logic [2:0] ec, input logic eo, input logic eu, input logic ef);
        exp_t e;
        e.sel = sel; e.tag = tag; e.pc = epc; e.valid = ev;
        e.cnt = ec; e.ovf = eo; e.unf = eu; e.fault = ef;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        compare(exp_q.pop_front());
    endtask

    initial begin
        exp_t e;
        reset_n64 = 1'b0; reset_n8 = 1'b0;
        b64.stall = 0; b64.redirect_en = 0; b64.redirect_target = '0; b64.call_en = 0;
        b64.ret_en = 0; b64.halt = 0; b64.resume = 0;
        b8.stall = 0; b8.redirect_en = 0; b8.redirect_target = '0; b8.call_en = 0;
        b8.ret_en = 0; b8.halt = 0; b8.resume = 0;

        step(0, "reset0", 64'h0, 0, 0, 0, 0, 0);
        step(0, "reset1", 64'h0, 0, 0, 0, 0, 0);
        reset_n64 = 1'b1;
        step(0, "boot", 64'h0, 1, 0, 0, 0, 0);
        step(0, "seq4", 64'h4, 1, 0, 0, 0, 0);
        step(0, "seq8", 64'h8, 1, 0, 0, 0, 0);

        b64.stall = 1;
        step(0, "stall1", 64'h8, 1, 0, 0, 0, 0);
        step(0, "stall2", 64'h8, 1, 0, 0, 0, 0);
        step(0, "stall3", 64'h8, 1, 0, 0, 0, 0);
        b64.stall = 0;
        step(0, "unstall", 64'hC, 1, 0, 0, 0, 0);
        b64.stall = 1; b64.redirect_en = 1; b64.redirect_target = 64'h100;
        step(0, "stall_redir", 64'h100, 1, 0, 0, 0, 0);
        b64.stall = 0; b64.call_en = 1; b64.redirect_target = 64'h400;
        step(0, "call", 64'h400, 1, 1, 0, 0, 0);
        b64.redirect_en = 0; b64.call_en = 0;
        step(0, "run404", 64'h404, 1, 1, 0, 0, 0);
        step(0, "run408", 64'h408, 1, 1, 0, 0, 0);
        b64.ret_en = 1;
        step(0, "ret", 64'h104, 1, 0, 0, 0, 0);
        b64.ret_en = 0; b64.call_en = 1;
        step(0, "call_noredir", 64'h108, 1, 0, 0, 0, 0);

        b64.redirect_en = 1;
        b64.redirect_target = 64'h1000; step(0, "call1", 64'h1000, 1, 1, 0, 0, 0);
        b64.redirect_target = 64'h2000; step(0, "call2", 64'h2000, 1, 2, 0, 0, 0);
        b64.redirect_target = 64'h3000; step(0, "call3", 64'h3000, 1, 3, 0, 0, 0);
        b64.redirect_target = 64'h4000; step(0, "call4", 64'h4000, 1, 4, 0, 0, 0);
        b64.redirect_target = 64'h5000; step(0, "call5_ovf", 64'h5000, 1, 4, 1, 0, 0);
        b64.redirect_en = 0; b64.call_en = 0; b64.ret_en = 1;
        step(0, "ret1", 64'h4004, 1, 3, 1, 0, 0);
        step(0, "ret2", 64'h3004, 1, 2, 1, 0, 0);
        step(0, "ret3", 64'h2004, 1, 1, 1, 0, 0);
        step(0, "ret4", 64'h1004, 1, 0, 1, 0, 0);
        step(0, "ret5_unf", 64'h1008, 1, 0, 1, 1, 0);
        b64.ret_en = 0;
        step(0, "after_unf", 64'h100C, 1, 0, 1, 1, 0);

        b64.redirect_en = 1; b64.call_en = 1; b64.redirect_target = 64'h6000;
        step(0, "call6", 64'h6000, 1, 1, 1, 1, 0);
        b64.call_en = 0; b64.ret_en = 1; b64.redirect_target = 64'h7000;
        step(0, "ret_vs_redir", 64'h7000, 1, 1, 1, 1, 0);
        b64.redirect_en = 0;
        step(0, "ret_after", 64'h1010, 1, 0, 1, 1, 0);
        b64.ret_en = 0;

        b64.redirect_en = 1; b64.redirect_target = 64'h203;
`ifdef PC_ALIGN_CHECK_EN
        step(0, "misalign", 64'h200, 1, 0, 1, 1, 1);
        b64.redirect_en = 0;
        step(0, "fault_clear", 64'h204, 1, 0, 1, 1, 0);
`else
        step(0, "misalign", 64'h203, 1, 0, 1, 1, 0);
        b64.redirect_en = 0;
        step(0, "fault_clear", 64'h207, 1, 0, 1, 1, 0);
`endif

        reset_n64 = 1'b0;
        #1;
        e.sel = 0; e.tag = "async_reset"; e.pc = 64'h0; e.valid = 0;
        e.cnt = 0; e.ovf = 0; e.unf = 0; e.fault = 0;
        compare(e);

        reset_n8 = 1'b1;
        step(1, "w8_boot", 64'hF4, 1, 0, 0, 0, 0);
        step(1, "w8_f8", 64'hF8, 1, 0, 0, 0, 0);
        step(1, "w8_fc", 64'hFC, 1, 0, 0, 0, 0);
        step(1, "w8_wrap", 64'h00, 1, 0, 0, 0, 0);
        b8.halt = 1;
        step(1, "w8_halt", 64'h04, 0, 0, 0, 0, 0);
        b8.halt = 0; b8.redirect_en = 1; b8.call_en = 1; b8.ret_en = 1; b8.redirect_target = 8'h80;
        step(1, "w8_ignore", 64'h04, 0, 0, 0, 0, 0);
        b8.redirect_en = 0; b8.call_en = 0; b8.ret_en = 0; b8.halt = 1; b8.resume = 1;
        step(1, "w8_both", 64'h04, 0, 0, 0, 0, 0);
        b8.halt = 0;
        step(1, "w8_resume", 64'h04, 1, 0, 0, 0, 0);
        b8.resume = 0;
        step(1, "w8_run", 64'h08, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
